// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler: round-robin sharing of one descriptor-controller slave
// between the PCIe read and write request queues, with per-channel credits.

// Per-channel outstanding-descriptor credit counter with sticky overflow flag.
module dma_desc_credit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue,
  input  logic       done,
  output logic [2:0] credit,
  output logic       error
);
  localparam logic [2:0] MAX_CREDIT = 3'(MAX_OUTSTANDING);

  // Issue and done on the same edge cancel; done at saturation only flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit <= MAX_CREDIT;
      error  <= 1'b0;
    end else if (done && !issue) begin
      if (credit == MAX_CREDIT) error <= 1'b1;
      else                      credit <= credit + 3'd1;
    end else if (issue && !done) begin
      credit <= credit - 3'd1;
    end
  end
endmodule

module dma_desc_scheduler #(
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [7:0]  RD_BASE         = 8'h00,
  parameter logic [7:0]  WR_BASE         = 8'h20,
  parameter logic [63:0] RD_STATUS_ADDR  = 64'h6000,
  parameter logic [63:0] WR_STATUS_ADDR  = 64'h7000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [111:0] rd_fifo_data,
  input  logic         rd_fifo_empty,
  output logic         rd_fifo_pop,
  input  logic [111:0] wr_fifo_data,
  input  logic         wr_fifo_empty,
  output logic         wr_fifo_pop,
  input  logic         rd_enable,
  input  logic         wr_enable,
  input  logic         rd_done,
  input  logic         wr_done,
  output logic         dcs_chip_select,
  output logic         dcs_write,
  output logic [7:0]   dcs_address,
  output logic [31:0]  dcs_write_data,
  output logic [3:0]   dcs_byte_enable,
  input  logic         dcs_wait_request,
  output logic [2:0]   rd_credit,
  output logic [2:0]   wr_credit,
  output logic         busy,
  output logic         credit_error
);
  // Channel 0 = read queue, channel 1 = write queue.
  localparam int NUM_CH = 2;

  typedef struct packed {
    logic [4:0]  padHi;
    logic [2:0]  dwCount;
    logic [39:0] padMid;
    logic [63:0] hostAddr;
  } qEntry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t   state, stateNext;
  logic     grantCh, grantNext;
  logic     rrPtr, rrNext;
  logic [2:0] word, wordNext;

  qEntry_t [NUM_CH-1:0]      head;
  logic [NUM_CH-1:0]         empty, enable, done, pop, eligible, chErr;
  logic [NUM_CH-1:0][2:0]    credit;

  qEntry_t     cur;
  logic [63:0] status;
  logic [7:0]  base;
  logic [2:0]  cntM1;
  logic [31:0] wordData;
  logic        unusedPad;

  assign head[0] = rd_fifo_data;
  assign head[1] = wr_fifo_data;
  assign empty   = {wr_fifo_empty, rd_fifo_empty};
  assign enable  = {wr_enable, rd_enable};
  assign done    = {wr_done, rd_done};
  assign unusedPad = ^{head[0].padHi, head[0].padMid, head[1].padHi, head[1].padMid};

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
      dma_desc_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) uCredit (
        .clock  (clock),
        .reset  (reset),
        .issue  (pop[ch]),
        .done   (done[ch]),
        .credit (credit[ch]),
        .error  (chErr[ch])
      );
      assign eligible[ch] = ~empty[ch] & enable[ch] & (credit[ch] != 3'd0);
    end
  endgenerate

  // Scheduler state, granted channel, word index and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grantCh <= 1'b0;
      rrPtr   <= 1'b0;
      word    <= 3'd0;
    end else begin
      state   <= stateNext;
      grantCh <= grantNext;
      rrPtr   <= rrNext;
      word    <= wordNext;
    end
  end

  // Grant selection in IDLE; word sequencing and pop on final accept in ISSUE.
  always_comb begin
    stateNext = state;
    grantNext = grantCh;
    rrNext    = rrPtr;
    wordNext  = word;
    pop       = '0;
    dcs_write = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          grantNext = (&eligible) ? rrPtr : eligible[1];
          wordNext  = 3'd0;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        dcs_write = 1'b1;
        if (!dcs_wait_request) begin
          if (word == 3'd4) begin
            pop[grantCh] = 1'b1;
            rrNext       = ~grantCh;
            stateNext    = IDLE;
          end else begin
            wordNext = word + 3'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Descriptor word mux from the granted queue head; slave bus idles at zero.
  always_comb begin
    cur      = head[grantCh];
    status   = grantCh ? WR_STATUS_ADDR : RD_STATUS_ADDR;
    base     = grantCh ? WR_BASE : RD_BASE;
    cntM1    = cur.dwCount - 3'd1;
    wordData = '0;
    case (word)
      3'd0:    wordData = status[31:0];
      3'd1:    wordData = status[63:32];
      3'd2:    wordData = cur.hostAddr[31:0];
      3'd3:    wordData = cur.hostAddr[63:32];
      default: wordData = {29'd0, cntM1};
    endcase
    dcs_address    = (state == ISSUE) ? base + 8'({word, 2'b00}) : 8'd0;
    dcs_write_data = (state == ISSUE) ? wordData : 32'd0;
  end

  assign rd_fifo_pop     = pop[0];
  assign wr_fifo_pop     = pop[1];
  assign dcs_chip_select = dcs_write;
  assign dcs_byte_enable = 4'hf;
  assign rd_credit       = credit[0];
  assign wr_credit       = credit[1];
  assign busy            = (state == ISSUE);
  assign credit_error    = |chErr;
endmodule
